// File: rtl/fsm_control_param_pkg.sv
// Shared state encodings and opcode constants for the multi-cycle CPU controller.
package cpu_ctrl_pkg;

    typedef enum logic [2:0] {
        FETCH,
        DECODE,
        EXECUTE,
        WRITEBACK,
        UPDATE_PC,
        HALT
    } state_t;

    localparam logic [3:0] OP_LDI  = 4'b1000;
    localparam logic [3:0] OP_BEQ  = 4'b1001;
    localparam logic [3:0] OP_JMP  = 4'b1010;
    localparam logic [3:0] OP_HALT = 4'b1011;

endpackage

// File: rtl/fsm_control_param_if.sv
// Controller <-> ROM/PC/ALU/register-file bundle. Optional macro: CTRL_RETIRE_CNT_EN adds retired_cnt.
interface fsm_control_param_if #(
    parameter int DATA_W  = 8,
    parameter int PC_W    = 5,
    parameter int REG_AW  = 3,
    parameter int INSTR_W = 16
);
    logic               rom_enable;
    logic               rom_valid;
    logic [INSTR_W-1:0] instr;
    logic [PC_W-1:0]    pc;
    logic               pc_inc;
    logic               pc_load;
    logic [PC_W-1:0]    pc_load_value;
    logic [2:0]         alu_opcode;
    logic [DATA_W-1:0]  alu_A;
    logic [DATA_W-1:0]  alu_B;
    logic               alu_start;
    logic               alu_done;
    logic [DATA_W-1:0]  alu_result;
    logic               we;
    logic [REG_AW-1:0]  w_address;
    logic [DATA_W-1:0]  w_data;
    logic [REG_AW-1:0]  r_address1;
    logic [REG_AW-1:0]  r_address2;
    logic [DATA_W-1:0]  r_data1;
    logic [DATA_W-1:0]  r_data2;
    logic               halted;
`ifdef CTRL_RETIRE_CNT_EN
    logic [31:0]        retired_cnt;
`endif

    modport master (
        output rom_enable, pc_inc, pc_load, pc_load_value, alu_opcode, alu_A, alu_B,
               alu_start, we, w_address, w_data, r_address1, r_address2, halted,
`ifdef CTRL_RETIRE_CNT_EN
        output retired_cnt,
`endif
        input  rom_valid, instr, pc, alu_done, alu_result, r_data1, r_data2
    );

    modport slave (
        input  rom_enable, pc_inc, pc_load, pc_load_value, alu_opcode, alu_A, alu_B,
               alu_start, we, w_address, w_data, r_address1, r_address2, halted,
`ifdef CTRL_RETIRE_CNT_EN
        input  retired_cnt,
`endif
        output rom_valid, instr, pc, alu_done, alu_result, r_data1, r_data2
    );

endinterface

// File: rtl/fsm_control_param_decode.sv
// Combinational field extraction and opcode-class flags from the latched instruction register.
module instr_decode
    import cpu_ctrl_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int REG_AW  = 3,
    parameter int INSTR_W = 16
) (
    input  logic [INSTR_W-1:0] i_ir,
    output logic [2:0]         o_alu_op,
    output logic [REG_AW-1:0]  o_rd,
    output logic [REG_AW-1:0]  o_rs1,
    output logic [REG_AW-1:0]  o_rs2,
    output logic [DATA_W-1:0]  o_imm,
    output logic               o_is_alu,
    output logic               o_is_ldi,
    output logic               o_is_beq,
    output logic               o_is_jmp,
    output logic               o_is_halt
);
    localparam int IMM_W = INSTR_W - 4 - REG_AW;

    logic [3:0] w_op;

    assign w_op      = i_ir[INSTR_W-1 -: 4];
    assign o_alu_op  = w_op[2:0];
    assign o_rd      = i_ir[INSTR_W-5 -: REG_AW];
    assign o_rs1     = i_ir[INSTR_W-5-REG_AW -: REG_AW];
    assign o_rs2     = i_ir[INSTR_W-5-2*REG_AW -: REG_AW];

    assign o_is_alu  = ~w_op[3];
    assign o_is_ldi  = (w_op == OP_LDI);
    assign o_is_beq  = (w_op == OP_BEQ);
    assign o_is_jmp  = (w_op == OP_JMP);
    assign o_is_halt = (w_op == OP_HALT);

    // Immediate overlaps rs1/rs2; zero-extend or truncate to the datapath width.
    generate
        if (DATA_W > IMM_W) begin : g_imm_zx
            assign o_imm = {{(DATA_W-IMM_W){1'b0}}, i_ir[IMM_W-1:0]};
        end else begin : g_imm_tr
            assign o_imm = i_ir[DATA_W-1:0];
        end
    endgenerate

endmodule

// File: rtl/fsm_control_param.sv
// Multi-cycle CPU control FSM: FETCH/DECODE/EXECUTE/WRITEBACK/UPDATE_PC/HALT.
// Optional macro: CTRL_RETIRE_CNT_EN adds a 32-bit retired-instruction counter.
module fsm_control_param
    import cpu_ctrl_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int PC_W    = 5,
    parameter int REG_AW  = 3,
    parameter int INSTR_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    fsm_control_param_if.master bus
);
    state_t              r_state, w_next;
    logic [INSTR_W-1:0]  r_ir;
    logic [DATA_W-1:0]   r_op_a, r_op_b, r_alu_res;
    logic                r_alu_wait;

    logic [2:0]          w_alu_op;
    logic [REG_AW-1:0]   w_rd, w_rs1, w_rs2;
    logic [DATA_W-1:0]   w_imm;
    logic                w_is_alu, w_is_ldi, w_is_beq, w_is_jmp, w_is_halt;
    logic [PC_W-1:0]     w_br_off;

    instr_decode #(.DATA_W(DATA_W), .REG_AW(REG_AW), .INSTR_W(INSTR_W)) u_dec (
        .i_ir      (r_ir),
        .o_alu_op  (w_alu_op),
        .o_rd      (w_rd),
        .o_rs1     (w_rs1),
        .o_rs2     (w_rs2),
        .o_imm     (w_imm),
        .o_is_alu  (w_is_alu),
        .o_is_ldi  (w_is_ldi),
        .o_is_beq  (w_is_beq),
        .o_is_jmp  (w_is_jmp),
        .o_is_halt (w_is_halt)
    );

    // Branch offset lives in the rd field, sign-extended to PC width.
    generate
        if (PC_W > REG_AW) begin : g_off_sx
            assign w_br_off = {{(PC_W-REG_AW){w_rd[REG_AW-1]}}, w_rd};
        end else begin : g_off_tr
            assign w_br_off = w_rd[PC_W-1:0];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= FETCH;
            r_ir       <= '0;
            r_op_a     <= '0;
            r_op_b     <= '0;
            r_alu_res  <= '0;
            r_alu_wait <= 1'b0;
        end else begin
            r_state <= w_next;
            if (r_state == FETCH && bus.rom_valid)
                r_ir <= bus.instr;
            if (r_state == DECODE) begin
                r_op_a <= bus.r_data1;
                r_op_b <= bus.r_data2;
            end
            // r_alu_wait suppresses alu_start after the first EXECUTE cycle.
            if (r_state == EXECUTE && w_is_alu) begin
                r_alu_wait <= !bus.alu_done;
                if (bus.alu_done)
                    r_alu_res <= bus.alu_result;
            end
        end
    end

    always_comb begin
        w_next            = r_state;
        bus.rom_enable    = 1'b0;
        bus.pc_inc        = 1'b0;
        bus.pc_load       = 1'b0;
        bus.pc_load_value = '0;
        bus.alu_opcode    = '0;
        bus.alu_A         = '0;
        bus.alu_B         = '0;
        bus.alu_start     = 1'b0;
        bus.we            = 1'b0;
        bus.w_address     = '0;
        bus.w_data        = '0;
        bus.r_address1    = '0;
        bus.r_address2    = '0;
        bus.halted        = 1'b0;
        case (r_state)
            FETCH: begin
                bus.rom_enable = 1'b1;
                if (bus.rom_valid)
                    w_next = DECODE;
            end
            DECODE: begin
                bus.r_address1 = w_rs1;
                bus.r_address2 = w_rs2;
                w_next         = EXECUTE;
            end
            EXECUTE: begin
                if (w_is_alu) begin
                    bus.alu_opcode = w_alu_op;
                    bus.alu_A      = r_op_a;
                    bus.alu_B      = r_op_b;
                    bus.alu_start  = !r_alu_wait;
                    if (bus.alu_done)
                        w_next = WRITEBACK;
                end else begin
                    w_next = w_is_ldi ? WRITEBACK : UPDATE_PC;
                end
            end
            WRITEBACK: begin
                bus.we        = 1'b1;
                bus.w_address = w_rd;
                bus.w_data    = w_is_alu ? r_alu_res : w_imm;
                w_next        = UPDATE_PC;
            end
            UPDATE_PC: begin
                if (w_is_halt) begin
                    w_next = HALT;
                end else begin
                    w_next = FETCH;
                    if (w_is_jmp) begin
                        bus.pc_load       = 1'b1;
                        bus.pc_load_value = r_ir[PC_W-1:0];
                    end else if (w_is_beq && r_op_a == r_op_b) begin
                        bus.pc_load       = 1'b1;
                        bus.pc_load_value = bus.pc + w_br_off;
                    end else begin
                        bus.pc_inc = 1'b1;
                    end
                end
            end
            HALT: begin
                bus.halted = 1'b1;
            end
            default: w_next = FETCH;
        endcase
    end

`ifdef CTRL_RETIRE_CNT_EN
    always_ff @(posedge clk) begin
        if (!rst_n)
            bus.retired_cnt <= '0;
        else if (r_state == UPDATE_PC)
            bus.retired_cnt <= bus.retired_cnt + 32'd1;
    end
`endif

endmodule

// File: tb/tb_fsm_control_param.sv
// Directed bench for fsm_control_param with small ROM, PC, ALU and register-file models.
module tb_fsm_control_param;
    localparam int DATA_W = 8, PC_W = 5, REG_AW = 3, INSTR_W = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fsm_control_param_if #(.DATA_W(DATA_W), .PC_W(PC_W), .REG_AW(REG_AW), .INSTR_W(INSTR_W)) bus ();

    fsm_control_param #(.DATA_W(DATA_W), .PC_W(PC_W), .REG_AW(REG_AW), .INSTR_W(INSTR_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    logic [INSTR_W-1:0] rom [32];
    logic [DATA_W-1:0]  regs [8];
    logic [PC_W-1:0]    pc_m = '0;
    int rom_delay = 0, rom_cnt = 0;
    int alu_delay = 0, alu_cnt = 0;
    bit alu_busy = 1'b0;

    assign bus.pc         = pc_m;
    assign bus.instr      = rom[pc_m];
    assign bus.rom_valid  = bus.rom_enable && (rom_cnt >= rom_delay);
    assign bus.alu_done   = (bus.alu_start && alu_delay == 0) || (alu_busy && alu_cnt >= alu_delay);
    assign bus.alu_result = bus.alu_A + bus.alu_B;
    assign bus.r_data1    = regs[bus.r_address1];
    assign bus.r_data2    = regs[bus.r_address2];

    // One clock: sample DUT strobes at negedge, then update the environment models after posedge.
    task automatic tick();
        logic s_rst, s_we, s_inc, s_ld, s_ren, s_rv, s_st, s_dn;
        logic [REG_AW-1:0] s_wa;
        logic [DATA_W-1:0] s_wd;
        logic [PC_W-1:0] s_plv;
        @(negedge clk);
        s_rst = rst_n; s_we = bus.we; s_wa = bus.w_address; s_wd = bus.w_data;
        s_inc = bus.pc_inc; s_ld = bus.pc_load; s_plv = bus.pc_load_value;
        s_ren = bus.rom_enable; s_rv = bus.rom_valid; s_st = bus.alu_start; s_dn = bus.alu_done;
        @(posedge clk);
        #1;
        if (!s_rst) begin
            pc_m = '0; rom_cnt = 0; alu_busy = 1'b0; alu_cnt = 0;
        end else begin
            if (s_inc) pc_m = pc_m + 1'b1;
            else if (s_ld) pc_m = s_plv;
            if (s_ren && !s_rv) rom_cnt++;
            else rom_cnt = 0;
            if (s_dn) alu_busy = 1'b0;
            else if (s_st) begin alu_busy = 1'b1; alu_cnt = 1; end
            else if (alu_busy) alu_cnt++;
            if (s_we) regs[s_wa] = s_wd;
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic clear_rom();
        for (int i = 0; i < 32; i++) rom[i] = 16'hC000;
    endtask

    task automatic run_until_upd(output bit ok, output bit ld, output bit inc, output logic [PC_W-1:0] val);
        ok = 1'b0; ld = 1'b0; inc = 1'b0; val = '0;
        for (int i = 0; i < 60; i++) begin
            tick();
            if (bus.pc_inc || bus.pc_load) begin
                ok = 1'b1; ld = bus.pc_load; inc = bus.pc_inc; val = bus.pc_load_value;
                return;
            end
        end
    endtask

    task automatic test_reset();
        clear_rom();
        rom[0] = 16'h22A0;
        alu_delay = 1000; rom_delay = 0;
        rst_n = 1'b0; tick(); tick(); rst_n = 1'b1;
        checks++;
        if ({bus.rom_enable, bus.pc_inc, bus.pc_load, bus.alu_start, bus.we, bus.halted} !== 6'b100000) begin
            errors++;
            $display("FAIL reset_strobes: got %b expected 100000",
                     {bus.rom_enable, bus.pc_inc, bus.pc_load, bus.alu_start, bus.we, bus.halted});
        end
        checks++;
        if ({bus.alu_A, bus.alu_B, bus.w_data, bus.w_address, bus.r_address1, bus.r_address2,
             bus.pc_load_value, bus.alu_opcode} !== '0) begin
            errors++;
            $display("FAIL reset_data: nonzero address/data after reset, alu_A=%h w_data=%h r_address1=%0d",
                     bus.alu_A, bus.w_data, bus.r_address1);
        end
        tick(); tick();
        checks++;
        if (bus.alu_start !== 1'b1) begin
            errors++;
            $display("FAIL exec_start: got alu_start=%b expected 1", bus.alu_start);
        end
        tick();
        rst_n = 1'b0; tick(); rst_n = 1'b1;
        checks++;
        if ({bus.rom_enable, bus.alu_start, bus.we, bus.halted, bus.alu_A} !== {4'b1000, 8'h00}) begin
            errors++;
            $display("FAIL reset_mid_exec: got rom_en/start/we/halted=%b alu_A=%h expected 1000 00",
                     {bus.rom_enable, bus.alu_start, bus.we, bus.halted}, bus.alu_A);
        end
    endtask

    task automatic test_ldi();
        int we_c, inc_c, st_n;
        logic [REG_AW-1:0] wa;
        logic [DATA_W-1:0] wd;
        we_c = 0; inc_c = 0; st_n = 0; wa = '0; wd = '0;
        clear_rom();
        rom[0] = 16'h87A0;
        rom_delay = 2; alu_delay = 0;
        do_reset();
        for (int c = 1; c <= 12; c++) begin
            if (bus.we && we_c == 0) begin we_c = c; wa = bus.w_address; wd = bus.w_data; end
            if (bus.pc_inc && inc_c == 0) inc_c = c;
            if (bus.alu_start) st_n++;
            tick();
        end
        checks++;
        if (we_c != 6 || wa !== 3'd3 || wd !== 8'hA0) begin
            errors++;
            $display("FAIL ldi_write: got cycle %0d addr %0d data %h expected cycle 6 addr 3 data a0", we_c, wa, wd);
        end
        checks++;
        if (inc_c != 7 || st_n != 0) begin
            errors++;
            $display("FAIL ldi_pc_inc: got inc cycle %0d alu_starts %0d expected 7 and 0", inc_c, st_n);
        end
        checks++;
        if (regs[3] !== 8'hA0) begin
            errors++;
            $display("FAIL ldi_regfile: got r3=%h expected a0", regs[3]);
        end
        rom_delay = 0;
    endtask

    task automatic test_alu();
        int we_c, inc_c, st_n, st_c, bad;
        logic [REG_AW-1:0] wa;
        logic [DATA_W-1:0] wd;
        we_c = 0; inc_c = 0; st_n = 0; st_c = 0; bad = 0; wa = '0; wd = '0;
        clear_rom();
        rom[0] = 16'h22A0;
        regs[2] = 8'h0F; regs[4] = 8'hF0;
        rom_delay = 0; alu_delay = 3;
        do_reset();
        for (int c = 1; c <= 12; c++) begin
            if (bus.alu_start) begin st_n++; if (st_c == 0) st_c = c; end
            if (c >= 3 && c <= 6 && (bus.alu_A !== 8'h0F || bus.alu_B !== 8'hF0 || bus.alu_opcode !== 3'b010)) bad++;
            if (bus.we && we_c == 0) begin we_c = c; wa = bus.w_address; wd = bus.w_data; end
            if (bus.pc_inc && inc_c == 0) inc_c = c;
            tick();
        end
        checks++;
        if (st_n != 1 || st_c != 3) begin
            errors++;
            $display("FAIL alu_start_pulse: got %0d pulses first at %0d expected 1 at 3", st_n, st_c);
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL alu_operands: got %0d unstable cycles expected 0", bad);
        end
        checks++;
        if (we_c != 7 || wa !== 3'd1 || wd !== 8'hFF) begin
            errors++;
            $display("FAIL alu_write: got cycle %0d addr %0d data %h expected cycle 7 addr 1 data ff", we_c, wa, wd);
        end
        checks++;
        if (inc_c != 8) begin
            errors++;
            $display("FAIL alu_latency: got pc_inc at cycle %0d expected 8", inc_c);
        end
    endtask

    task automatic test_beq();
        bit ok, ld, inc;
        logic [PC_W-1:0] val;
        clear_rom();
        rom[2] = 16'h9C48;
        alu_delay = 0;
        do_reset();
        run_until_upd(ok, ld, inc, val);
        run_until_upd(ok, ld, inc, val);
        run_until_upd(ok, ld, inc, val);
        checks++;
        if (!ok || ld !== 1'b1 || inc !== 1'b0 || val !== 5'd0) begin
            errors++;
            $display("FAIL beq_back2: got ok=%b load=%b inc=%b value=%0d expected 1 1 0 0", ok, ld, inc, val);
        end
        clear_rom();
        rom[0] = 16'h9E48;
        rom[31] = 16'h92A0;
        regs[2] = 8'h0F; regs[4] = 8'hF0;
        do_reset();
        run_until_upd(ok, ld, inc, val);
        checks++;
        if (!ok || ld !== 1'b1 || val !== 5'd31) begin
            errors++;
            $display("FAIL beq_wrap: got ok=%b load=%b value=%0d expected 1 1 31", ok, ld, val);
        end
        run_until_upd(ok, ld, inc, val);
        tick();
        checks++;
        if (!ok || inc !== 1'b1 || ld !== 1'b0 || pc_m !== 5'd0) begin
            errors++;
            $display("FAIL beq_not_taken: got ok=%b inc=%b load=%b pc=%0d expected 1 1 0 0", ok, inc, ld, pc_m);
        end
    endtask

    task automatic test_jmp_halt();
        bit ok, ld, inc;
        logic [PC_W-1:0] val;
        int h_c, strobes, bad;
        h_c = 0; strobes = 0; bad = 0;
        clear_rom();
        rom[0] = 16'hA01C;
        rom[28] = 16'hB000;
        do_reset();
        run_until_upd(ok, ld, inc, val);
        checks++;
        if (!ok || ld !== 1'b1 || inc !== 1'b0 || val !== 5'h1C) begin
            errors++;
            $display("FAIL jmp_target: got ok=%b load=%b inc=%b value=%h expected 1 1 0 1c", ok, ld, inc, val);
        end
        for (int c = 1; c <= 40; c++) begin
            tick();
            if (bus.halted) begin h_c = c; break; end
            if (bus.pc_inc || bus.pc_load) strobes++;
        end
        checks++;
        if (h_c != 5 || strobes != 0 || pc_m !== 5'h1C) begin
            errors++;
            $display("FAIL halt_entry: got halted at %0d strobes %0d pc %h expected 5 0 1c", h_c, strobes, pc_m);
        end
        for (int c = 0; c < 20; c++) begin
            tick();
            if (!bus.halted || bus.pc_inc || bus.pc_load || bus.rom_enable || bus.we || bus.alu_start) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL halt_sticky: got %0d bad cycles expected 0", bad);
        end
    endtask

    task automatic test_back_to_back();
        int st_n;
        st_n = 0;
        clear_rom();
        rom[0] = 16'h8A33;
        rom[1] = 16'h0D68;
        regs[5] = 8'h00; regs[6] = 8'h00;
        alu_delay = 0; rom_delay = 0;
        do_reset();
        for (int c = 1; c <= 10; c++) begin
            if (bus.alu_start) st_n++;
            tick();
        end
        checks++;
        if (regs[5] !== 8'h33 || regs[6] !== 8'h66) begin
            errors++;
            $display("FAIL b2b_regs: got r5=%h r6=%h expected 33 66", regs[5], regs[6]);
        end
        checks++;
        if (pc_m !== 5'd2 || bus.rom_enable !== 1'b1 || st_n != 1) begin
            errors++;
            $display("FAIL b2b_latency: got pc=%0d rom_enable=%b starts=%0d expected 2 1 1", pc_m, bus.rom_enable, st_n);
        end
    endtask

`ifdef CTRL_RETIRE_CNT_EN
    task automatic test_retire();
        clear_rom();
        rom[9] = 16'hB000;
        do_reset();
        checks++;
        if (bus.retired_cnt !== 32'd0) begin
            errors++;
            $display("FAIL retire_reset: got %0d expected 0", bus.retired_cnt);
        end
        for (int c = 0; c < 80; c++) begin
            if (bus.halted) break;
            tick();
        end
        checks++;
        if (!bus.halted || bus.retired_cnt !== 32'd10) begin
            errors++;
            $display("FAIL retire_count: got halted=%b count=%0d expected 1 10", bus.halted, bus.retired_cnt);
        end
        for (int c = 0; c < 5; c++) tick();
        checks++;
        if (bus.retired_cnt !== 32'd10) begin
            errors++;
            $display("FAIL retire_hold: got %0d expected 10", bus.retired_cnt);
        end
    endtask
`endif

    initial begin
        for (int i = 0; i < 8; i++) regs[i] = 8'h00;
        clear_rom();
        test_reset();
        test_ldi();
        test_alu();
        test_beq();
        test_jmp_halt();
        test_back_to_back();
`ifdef CTRL_RETIRE_CNT_EN
        test_retire();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
